// File: rtl/opfetch_pkg.sv
// rtl/opfetch_pkg.sv - operand_fetch default widths, skid-buffer state encoding and entry layout
package opfetch_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_OP_W   = 6;
    localparam int IMM_W          = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] a;
        logic [DEFAULT_DATA_W-1:0] b;
        logic [DEFAULT_DATA_W-1:0] imm;
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_OP_W-1:0]   op;
    } entry_t;

    localparam int DEFAULT_ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode-side and execute-side handshakes of operand_fetch
interface operand_fetch_if #(
    parameter int DATA_W = opfetch_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = opfetch_pkg::DEFAULT_ADDR_W,
    parameter int OP_W   = opfetch_pkg::DEFAULT_OP_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic [15:0]       in_imm;
    logic [OP_W-1:0]   in_op;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_imm;
    logic [ADDR_W-1:0] out_rd;
    logic [OP_W-1:0]   out_op;

    // master is the surrounding pipeline (decode feeding, execute draining)
    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_imm, in_op, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_imm, out_rd, out_op
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_imm, in_op, out_ready,
        output in_ready, out_valid, out_a, out_b, out_imm, out_rd, out_op
    );
endinterface

// File: rtl/opfetch_entry.sv
// rtl/opfetch_entry.sv - one skid-buffer slot holding a packed a/b/imm/rd/op entry
module opfetch_entry #(
    parameter int W = opfetch_pkg::DEFAULT_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage with 2-entry skid buffer; define OPERAND_FETCH_BYPASS_EN
// for same-edge writeback bypass, otherwise hazards against the writeback port stall in_ready.
module operand_fetch
    import opfetch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int OP_W   = DEFAULT_OP_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    operand_fetch_if.slave    bus,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data
);
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rd;
        logic [OP_W-1:0]   op;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    state_t            state, state_nxt;
    logic              rd_ptr;
    logic              in_ready_q;
    logic              hazard;
    logic              in_acc, out_acc;
    logic              wr_sel;
    logic [1:0]        load;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    slot_t             wr_slot, head;
    logic [SLOT_W-1:0] slot_q [2];

    assign ReadRegister1 = bus.in_rs;
    assign ReadRegister2 = bus.in_rt;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign hazard = 1'b0;
    assign opnd_a = (bus.in_rs == '0) ? '0 :
                    (wb_valid && wb_reg == bus.in_rs) ? wb_data : ReadData1;
    assign opnd_b = (bus.in_rt == '0) ? '0 :
                    (wb_valid && wb_reg == bus.in_rt) ? wb_data : ReadData2;
`else
    // Writeback data reaches us through the regfile one cycle later instead.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign hazard = wb_valid && (wb_reg != '0) &&
                    ((wb_reg == bus.in_rs) || (wb_reg == bus.in_rt));
    assign opnd_a = (bus.in_rs == '0) ? '0 : ReadData1;
    assign opnd_b = (bus.in_rt == '0) ? '0 : ReadData2;
`endif

    assign bus.in_ready  = in_ready_q && !hazard;
    assign bus.out_valid = (state != ST_EMPTY);
    assign in_acc        = bus.in_valid && bus.in_ready;
    assign out_acc       = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_slot     = '0;
        wr_slot.a   = opnd_a;
        wr_slot.b   = opnd_b;
        wr_slot.imm = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
        wr_slot.rd  = bus.in_rd;
        wr_slot.op  = bus.in_op;
    end

    // With one entry held the new one goes behind it; when empty it becomes the head.
    assign wr_sel = (state == ST_EMPTY) ? rd_ptr : ~rd_ptr;

    always_comb begin
        load = '0;
        if (in_acc) begin
            load[wr_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        opfetch_entry #(.W(SLOT_W)) u_slot (
            .clk   (Clk),
            .rst_n (Reset_n),
            .load  (load[i]),
            .d     (wr_slot),
            .q     (slot_q[i])
        );
    end

    assign head        = slot_t'(slot_q[rd_ptr]);
    assign bus.out_a   = head.a;
    assign bus.out_b   = head.b;
    assign bus.out_imm = head.imm;
    assign bus.out_rd  = head.rd;
    assign bus.out_op  = head.op;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY: if (in_acc) state_nxt = ST_ONE;
            ST_ONE: begin
                if (in_acc && !out_acc) begin
                    state_nxt = ST_TWO;
                end else if (!in_acc && out_acc) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO:   if (out_acc) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_EMPTY;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
            if (out_acc) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end
endmodule
